// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_pkg: shared types and sizes for the register-file writeback path.
//   DW / AW / NUM_REGS : data width, address width, register count
//   reg_addr_t         : register address
//   reg_data_t         : register data word
//   wb_pri_e           : round-robin priority state of the writeback arbiter
package regfile_pkg;

  localparam int DW       = 8;
  localparam int AW       = 4;
  localparam int NUM_REGS = 16;

  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [DW-1:0] reg_data_t;

  typedef enum logic {
    PRI_ALU = 1'b0,
    PRI_MEM = 1'b1
  } wb_pri_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: the two writeback valid/ready channels (ALU and
// memory/load) that compete for the single reg_file write port.
//   alu_valid/alu_dest/alu_data : ALU request, held stable until alu_ready
//   mem_valid/mem_dest/mem_data : load request, held stable until mem_ready
//   alu_ready/mem_ready         : acceptance, combinational from the arbiter
// Modports: master = writeback sources, slave = arbiter.
interface regfile_wb_arbiter_if;
  import regfile_pkg::*;

  logic      alu_valid;
  logic      alu_ready;
  reg_addr_t alu_dest;
  reg_data_t alu_data;

  logic      mem_valid;
  logic      mem_ready;
  reg_addr_t mem_dest;
  reg_data_t mem_data;

  modport master (
    output alu_valid, alu_dest, alu_data,
    output mem_valid, mem_dest, mem_data,
    input  alu_ready, mem_ready
  );

  modport slave (
    input  alu_valid, alu_dest, alu_data,
    input  mem_valid, mem_dest, mem_data,
    output alu_ready, mem_ready
  );

endinterface

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// wb_scoreboard: per-register pending-write flags used by issue logic to
// stall on RAW hazards.
//   clk, reset      : clock, synchronous active-high reset
//   setEn, setAddr  : an instruction issued with this destination
//   clrEn, clrAddr  : a write to this register commits this cycle
//   busyVec         : bit i high while register i has a pending write
// When the same register is set and cleared together, the set wins so the
// newer writer stays tracked.
module wb_scoreboard
  import regfile_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                setEn,
  input  reg_addr_t           setAddr,
  input  logic                clrEn,
  input  reg_addr_t           clrAddr,
  output logic [NUM_REGS-1:0] busyVec
);

  always_ff @(posedge clk) begin
    if (reset) begin
      busyVec <= '0;
    end else begin
      // Set is applied after clear so it overrides on an address collision.
      if (clrEn) busyVec[clrAddr] <= 1'b0;
      if (setEn) busyVec[setAddr] <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the single write port of the 16x8 reg_file
// between the ALU and the memory/load writeback sources, and keeps a busy
// scoreboard of destinations with pending writes.
//   clk, reset                     : clock, synchronous active-high reset
//   wb (slave modport)             : ALU and memory valid/ready channels
//   issue_valid, issue_dest        : issuing instruction marks its destination busy
//   busy_vec                       : pending-write flags per register
//   RegWrite, write_register, data_in : reg_file write port, one cycle after grant
// Optional (macro WB_FORWARD_EN):
//   raddrA/raddrB -> fwd_hitA/fwd_hitB, fwd_dataA/fwd_dataB bypass of the
//   write being committed this cycle.
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  regfile_wb_arbiter_if.slave wb,
  input  logic                issue_valid,
  input  reg_addr_t           issue_dest,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                RegWrite,
  output reg_addr_t           write_register,
  output reg_data_t           data_in
`ifdef WB_FORWARD_EN
  ,
  input  reg_addr_t           raddrA,
  input  reg_addr_t           raddrB,
  output logic                fwd_hitA,
  output logic                fwd_hitB,
  output reg_data_t           fwd_dataA,
  output reg_data_t           fwd_dataB
`endif
);

  wb_pri_e pri;
  logic    grantAlu;
  logic    grantMem;

  // Stage 0: arbitration. A lone requester always wins; on contention the
  // source named by pri wins. Nothing is accepted while reset is held so an
  // in-flight request cannot slip through.
  always_comb begin
    grantAlu = 1'b0;
    grantMem = 1'b0;
    if (!reset) begin
      grantAlu = wb.alu_valid && (!wb.mem_valid || pri == PRI_ALU);
      grantMem = wb.mem_valid && (!wb.alu_valid || pri == PRI_MEM);
    end
  end

  assign wb.alu_ready = grantAlu;
  assign wb.mem_ready = grantMem;

  // Stage 1: write stage registers driving the reg_file port.
  always_ff @(posedge clk) begin
    if (reset) begin
      pri            <= PRI_ALU;
      RegWrite       <= 1'b0;
      write_register <= '0;
      data_in        <= '0;
    end else begin
      // Priority only rotates when both sources competed.
      if (wb.alu_valid && wb.mem_valid)
        pri <= (pri == PRI_ALU) ? PRI_MEM : PRI_ALU;
      RegWrite <= grantAlu || grantMem;
      if (grantAlu) begin
        write_register <= wb.alu_dest;
        data_in        <= wb.alu_data;
      end else if (grantMem) begin
        write_register <= wb.mem_dest;
        data_in        <= wb.mem_data;
      end
    end
  end

  wb_scoreboard uScoreboard (
    .clk     (clk),
    .reset   (reset),
    .setEn   (issue_valid),
    .setAddr (issue_dest),
    .clrEn   (RegWrite),
    .clrAddr (write_register),
    .busyVec (busy_vec)
  );

`ifdef WB_FORWARD_EN
  // Bypass the write committing this cycle, since reg_file returns old data
  // on a same-cycle read.
  assign fwd_hitA  = RegWrite && (write_register == raddrA);
  assign fwd_hitB  = RegWrite && (write_register == raddrB);
  assign fwd_dataA = data_in;
  assign fwd_dataB = data_in;
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 16x8 reg_file between two writeback sources: the ALU and the memory/load path.
- Each source connects through a valid/ready handshake.
- Holds a busy scoreboard of destination registers that issue logic reads to stall on RAW hazards.
- Sits between execute/memory stages and reg_file; drives reg_file's RegWrite, write_register and data_in.

Parameters:
- DW, 8, data width of the register file
- AW, 4, register address width
- NUM_REGS, 16, number of registers; must equal 2**AW

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous active-high reset
- issue_valid  input  1  an instruction with a register destination issues this cycle
- issue_dest  input  AW  destination register of the issuing instruction
- busy_vec  output  NUM_REGS  bit i high while register i has a pending write
- alu_valid  input  1  ALU writeback request
- alu_ready  output  1  ALU request accepted this cycle
- alu_dest  input  AW  ALU destination register
- alu_data  input  DW  ALU result
- mem_valid  input  1  memory writeback request
- mem_ready  output  1  memory request accepted this cycle
- mem_dest  input  AW  memory destination register
- mem_data  input  DW  load data
- RegWrite  output  1  write enable to reg_file
- write_register  output  AW  write address to reg_file
- data_in  output  DW  write data to reg_file

Behaviour:
- Reset: clk is the only clock; reset is synchronous, active-high.
  - On reset: RegWrite=0, write_register=0, data_in=0, busy_vec=0, priority state=PRI_ALU.
  - If reset is asserted mid-operation, it drops any in-flight write, so RegWrite=0 in the next cycle.
- Handshake: a transfer occurs when valid&&ready in the same cycle.
  - ready is combinational from valid and the priority state.
  - A source holds valid, dest and data stable until accepted.
- Arbitration, two-state round-robin FSM (PRI_ALU, PRI_MEM):
  - Only one source valid: that source is granted.
  - Both valid: the source named by the state is granted, and the state moves to the other source.
  - Neither valid: the state is unchanged.
  - At most one ready is high per cycle.
- Write stage latency: a grant in cycle N registers dest/data.
  - RegWrite=1 in cycle N+1 with write_register/data_in from the granted source.
  - reg_file commits at the end of N+1.
  - With no grant in cycle N, RegWrite=0 in N+1; write_register/data_in hold their last values.
- Scoreboard:
  - issue_valid sets busy_vec[issue_dest] at the clock edge.
  - A write commit (RegWrite=1) clears busy_vec[write_register] at the clock edge.
  - Set and clear of the same register in the same cycle: set wins, so the bit stays 1 for the newer writer.
  - Set/clear of different registers apply independently.
  - A grant to a register whose busy bit is 0 is legal: the write still occurs and the bit remains 0.
- Back-to-back: the arbiter sustains one accepted write per cycle with no bubble.

Optional Feature:
- Macro: WB_FORWARD_EN.
- Enabled, the block adds these ports:
  - raddrA, raddrB (input, AW)
  - fwd_hitA, fwd_hitB (output, 1)
  - fwd_dataA, fwd_dataB (output, DW)
- fwd_hitX=RegWrite&&(write_register==raddrX), combinational; fwd_dataX=data_in. This bypasses reg_file read-during-write.
- Disabled: these ports and their logic are absent; behaviour otherwise identical.

Decomposition:
- Shared package regfile_pkg holds:
  - localparams DW=8, AW=4, NUM_REGS=16
  - typedef logic [AW-1:0] reg_addr_t
  - typedef logic [DW-1:0] reg_data_t
  - enum wb_pri_e {PRI_ALU, PRI_MEM}
- One sub-module, wb_scoreboard: busy_vec set/clear logic with set-wins priority.
- Arbiter FSM and write stage stay in the top module.

Test Plan:
- Reset held 2 cycles with alu_valid=1 -> RegWrite=0, busy_vec=16'h0000, alu_ready=0 during reset.
- Single ALU request, alu_dest=4'hE, alu_data=8'd255 -> alu_ready=1 in cycle N; RegWrite=1, write_register=E, data_in=255 in N+1; a reg_file read of E returns 255 afterwards.
- Both valid for 4 cycles (alu_dest=9, data 200; mem_dest=3, data 155) from reset -> grant order ALU, MEM, ALU, MEM; RegWrite high for 4 consecutive cycles.
- issue_valid with issue_dest=4, then ALU writeback of 4 two cycles later -> busy_vec[4]=1 from the first edge, clears at the edge ending the RegWrite cycle.
- issue_valid with issue_dest=3 in the same cycle RegWrite=1 with write_register=3 -> busy_vec[3] stays 1.
- WB_FORWARD_EN defined, raddrA=4'h3 while RegWrite=1, write_register=3, data_in=8'd1 -> fwd_hitA=1, fwd_dataA=1; raddrB=4'h4 -> fwd_hitB=0.
